cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_capture_pkg.sv | 27 ++
 rtl/cam_capture_rgb565_pack.sv | 42 ++++
 rtl/cam_capture.sv | 147 ++++++++++++++
 tb/tb_cam_capture.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
// Shared video-timing package: active raster size, frame-buffer address width and pixel formats.
package cam_capture_pkg;

    localparam int unsigned H_ACTIVE      = 640;
    localparam int unsigned V_ACTIVE      = 480;
    localparam int unsigned FRAME_PIXELS  = H_ACTIVE * V_ACTIVE;
    localparam int unsigned SKIP_DEFAULT  = 10;
    localparam int unsigned ADDR_W        = 19;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned R_W           = 4;
    localparam int unsigned G_W           = 4;
    localparam int unsigned B_W           = 4;
    localparam int unsigned PIX_W         = R_W + G_W + B_W;

    typedef enum logic [1:0] {
        ST_SKIP    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb444_t;

endpackage

// File: rtl/cam_capture_rgb565_pack.sv
// Assembles two RGB565 camera bytes into one truncated RGB444 pixel.
module rgb565_pack
    import cam_capture_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              href_i,
    input  logic              phase_i,
    output rgb444_t           pixel_c,
    output logic              valid_c
);

    logic [BYTE_W-1:0] hi_q;
    logic [BYTE_W-1:0] hi_d;
    logic              unused_bits_c;

    always_comb begin
        hi_d = hi_q;
        if (href_i && !phase_i) begin
            hi_d = byte_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end

    // Phase-0 byte is {R[4:0],G[5:3]}, phase-1 byte is {G[2:0],B[4:0]}; keep the top bits of each.
    always_comb begin
        pixel_c.r     = hi_q[7:4];
        pixel_c.g     = {hi_q[2:0], byte_i[7]};
        pixel_c.b     = byte_i[4:1];
        valid_c       = href_i && phase_i;
        unused_bits_c = ^{hi_q[3], byte_i[6:5], byte_i[0]};
    end

endmodule

// File: rtl/cam_capture.sv
// Camera capture: skips settling frames, then writes RGB444 pixels of enabled frames in raster order.
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int unsigned H_ACTIVE_TIME = H_ACTIVE,
    parameter int unsigned V_ACTIVE_TIME = V_ACTIVE,
    parameter int unsigned SKIP_FRAMES   = SKIP_DEFAULT
) (
    input  logic              cam_pclk,
    input  logic              rst_n,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [BYTE_W-1:0] cam_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int unsigned FRAME_SIZE = H_ACTIVE_TIME * V_ACTIVE_TIME;
    localparam int unsigned SKIP_W     = $clog2(SKIP_FRAMES + 2);

    logic              vsync_q, vsync_d, vs_prev_q, vs_prev_d, href_q, href_d;
    logic [BYTE_W-1:0] data_q, data_d;
    cap_state_e        state_q, state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    rgb444_t           ram_wdata_q, ram_wdata_d;
    logic              frame_done_q, frame_done_d, frame_err_q, frame_err_d;
    logic              vs_rise_c;
    logic              pix_valid_c;
    rgb444_t           pix_c;

    rgb565_pack u_pack (
        .clk     (cam_pclk),
        .rst_n   (rst_n),
        .byte_i  (data_q),
        .href_i  (href_q),
        .phase_i (phase_q),
        .pixel_c (pix_c),
        .valid_c (pix_valid_c)
    );

    // Input stage and byte phase; a frame boundary also drops any half-assembled pixel.
    always_comb begin
        vsync_d   = cam_vsync;
        vs_prev_d = vsync_q;
        href_d    = cam_href;
        data_d    = cam_data;
        vs_rise_c = vsync_q && !vs_prev_q;
        phase_d   = (href_q && !vs_rise_c) ? !phase_q : 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;
        case (state_q)
            ST_SKIP: begin
                if (vs_rise_c) begin
                    if (32'(skip_cnt_q) + 32'd1 >= SKIP_FRAMES) begin
                        state_d    = ST_IDLE;
                        skip_cnt_d = '0;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (vs_rise_c && capture_en) begin
                    state_d   = ST_CAPTURE;
                    pix_cnt_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (vs_rise_c) begin
                    frame_done_d = 1'b1;
                    frame_err_d  = (pix_cnt_q != ADDR_W'(FRAME_SIZE));
                    pix_cnt_d    = '0;
                    if (!capture_en) begin
                        state_d = ST_IDLE;
                    end
                end else if (pix_valid_c) begin
                    // Pixel counter doubles as write address; excess pixels are counted but not written.
                    if (pix_cnt_q < ADDR_W'(FRAME_SIZE)) begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = pix_cnt_q;
                        ram_wdata_d = pix_c;
                    end
                    if (pix_cnt_q != '1) begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_SKIP;
        endcase
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            vs_prev_q    <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            state_q      <= ST_SKIP;
            skip_cnt_q   <= '0;
            phase_q      <= 1'b0;
            pix_cnt_q    <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            vsync_q      <= vsync_d;
            vs_prev_q    <= vs_prev_d;
            href_q       <= href_d;
            data_q       <= data_d;
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            phase_q      <= phase_d;
            pix_cnt_q    <= pix_cnt_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a reduced 4x3 raster with a 2-frame settling window.
module tb_cam_capture;

    localparam int unsigned H     = 4;
    localparam int unsigned V     = 3;
    localparam int unsigned SKIP  = 2;
    localparam int          FRAME = H * V;
    localparam int          LBYTES = 2 * H;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [11:0] exp;
    } vec_t;

    logic        cam_pclk   = 1'b0;
    logic        rst_n      = 1'b0;
    logic        capture_en = 1'b0;
    logic        cam_vsync  = 1'b0;
    logic        cam_href   = 1'b0;
    logic [7:0]  cam_data   = 8'h00;
    logic        ram_we;
    logic [18:0] ram_addr;
    logic [11:0] ram_wdata;
    logic        frame_done;
    logic        frame_err;

    int          checks = 0;
    int          errors = 0;
    int          wr_count, addr_bad, data_bad, fd_count, first_addr, last_addr;
    logic [11:0] exp_wdata = 12'hF0F;
    logic [11:0] last_wdata;
    vec_t        vecs [6];

    always #5 cam_pclk = ~cam_pclk;

    cam_capture #(
        .H_ACTIVE_TIME (H),
        .V_ACTIVE_TIME (V),
        .SKIP_FRAMES   (SKIP)
    ) dut (
        .cam_pclk   (cam_pclk),
        .rst_n      (rst_n),
        .capture_en (capture_en),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    // Write/frame_done observer, sampled on the inactive edge.
    always @(negedge cam_pclk) begin
        if (ram_we === 1'b1) begin
            if (wr_count == 0) first_addr = int'(ram_addr);
            if (int'(ram_addr) != wr_count) addr_bad++;
            if (ram_wdata !== exp_wdata) data_bad++;
            last_addr  = int'(ram_addr);
            last_wdata = ram_wdata;
            wr_count++;
        end
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic tick();
        @(posedge cam_pclk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        wr_count   = 0;
        addr_bad   = 0;
        data_bad   = 0;
        fd_count   = 0;
        first_addr = -1;
        last_addr  = -1;
    endtask

    task automatic vsync_pulse();
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        repeat (4) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_line(input int nbytes, input logic [7:0] hi, input logic [7:0] lo);
        for (int b = 0; b < nbytes; b++) begin
            cam_href = 1'b1;
            cam_data = (b % 2 == 0) ? hi : lo;
            tick();
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (3) tick();
    endtask

    task automatic send_frame(input int lines, input int nbytes, input logic [7:0] hi, input logic [7:0] lo);
        for (int l = 0; l < lines; l++) send_line(nbytes, hi, lo);
    endtask

    task automatic check_full_frame(input string name);
        check({name, " writes"}, wr_count, FRAME);
        check({name, " first_addr"}, first_addr, 0);
        check({name, " last_addr"}, last_addr, FRAME - 1);
        check({name, " addr_seq"}, addr_bad, 0);
        check({name, " data"}, data_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'hF8, 8'h1F, 12'hF0F};
        vecs[1] = '{8'h07, 8'hE0, 12'h0F0};
        vecs[2] = '{8'hFF, 8'hFF, 12'hFFF};
        vecs[3] = '{8'h00, 8'h00, 12'h000};
        vecs[4] = '{8'hA5, 8'h5A, 12'hAAD};
        vecs[5] = '{8'h12, 8'h34, 12'h14A};
        clear_stats();

        repeat (3) tick();
        check("rst ram_we", int'(ram_we), 0);
        check("rst ram_addr", int'(ram_addr), 0);
        check("rst ram_wdata", int'(ram_wdata), 0);
        check("rst frame_done", int'(frame_done), 0);
        check("rst frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        capture_en = 1'b1;
        repeat (2) tick();

        // Settling window: no writes, no frame_done.
        for (int k = 0; k < int'(SKIP); k++) begin
            vsync_pulse();
            send_frame(V, LBYTES, 8'hF8, 8'h1F);
        end
        check("skip writes", wr_count, 0);
        check("skip frame_done", fd_count, 0);

        vsync_pulse();
        clear_stats();
        send_frame(V, LBYTES, 8'hF8, 8'h1F);
        check_full_frame("first");
        vsync_pulse();
        check("first frame_done", fd_count, 1);
        check("first frame_err", int'(frame_err), 0);

        // Short frame, then a good one clears the error.
        clear_stats();
        send_frame(V - 1, LBYTES, 8'hF8, 8'h1F);
        check("short writes", wr_count, FRAME - H);
        vsync_pulse();
        check("short frame_done", fd_count, 1);
        check("short frame_err", int'(frame_err), 1);
        clear_stats();
        send_frame(V, LBYTES, 8'hF8, 8'h1F);
        check("err held", int'(frame_err), 1);
        check_full_frame("recover");
        vsync_pulse();
        check("recover frame_err", int'(frame_err), 0);

        // Odd trailing byte on every line.
        exp_wdata = 12'h14A;
        clear_stats();
        send_frame(V, LBYTES + 1, 8'h12, 8'h34);
        check_full_frame("odd");
        vsync_pulse();
        check("odd frame_err", int'(frame_err), 0);

        // One line too many: extra pixels dropped, address stays at the last slot.
        exp_wdata = 12'hF0F;
        clear_stats();
        send_frame(V + 1, LBYTES, 8'hF8, 8'h1F);
        check_full_frame("over");
        check("over ram_addr held", int'(ram_addr), FRAME - 1);
        vsync_pulse();
        check("over frame_err", int'(frame_err), 1);

        // Colour conversion table.
        clear_stats();
        foreach (vecs[i]) begin
            exp_wdata = vecs[i].exp;
            cam_href = 1'b1;
            cam_data = vecs[i].hi;
            tick();
            cam_data = vecs[i].lo;
            tick();
            cam_href = 1'b0;
            cam_data = 8'h00;
            repeat (3) tick();
            check($sformatf("vec%0d wdata", i), int'(last_wdata), int'(vecs[i].exp));
            check($sformatf("vec%0d addr", i), last_addr, i);
        end
        vsync_pulse();
        check("vec frame_err", int'(frame_err), 1);

        // capture_en dropped mid-frame: frame completes, next frame idle.
        exp_wdata = 12'hF0F;
        clear_stats();
        send_line(LBYTES, 8'hF8, 8'h1F);
        capture_en = 1'b0;
        send_frame(V - 1, LBYTES, 8'hF8, 8'h1F);
        check_full_frame("en_drop");
        vsync_pulse();
        check("en_drop frame_done", fd_count, 1);
        check("en_drop frame_err", int'(frame_err), 0);
        clear_stats();
        send_frame(V, LBYTES, 8'hF8, 8'h1F);
        check("idle writes", wr_count, 0);
        capture_en = 1'b1;
        vsync_pulse();
        check("idle frame_done", fd_count, 0);
        clear_stats();
        send_frame(V, LBYTES, 8'hF8, 8'h1F);
        check_full_frame("resume");
        vsync_pulse();

        // vsync rises while href is high, exactly on a phase-1 byte.
        clear_stats();
        cam_href = 1'b1;
        cam_data = 8'hF8; tick();
        cam_data = 8'h1F; tick();
        cam_data = 8'hF8; tick();
        cam_vsync = 1'b1;
        cam_data = 8'h1F; tick();
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
        check("vs_href writes", wr_count, 1);
        check("vs_href frame_done", fd_count, 1);
        check("vs_href frame_err", int'(frame_err), 1);

        // Reset in the middle of a line.
        clear_stats();
        send_line(LBYTES, 8'hF8, 8'h1F);
        cam_href = 1'b1;
        cam_data = 8'hF8; tick();
        cam_data = 8'h1F; tick();
        cam_data = 8'hF8; tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst ram_we", int'(ram_we), 0);
        check("mid_rst ram_addr", int'(ram_addr), 0);
        check("mid_rst ram_wdata", int'(ram_wdata), 0);
        check("mid_rst frame_done", int'(frame_done), 0);
        check("mid_rst frame_err", int'(frame_err), 0);
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_stats();
        for (int k = 0; k < int'(SKIP); k++) begin
            vsync_pulse();
            send_frame(V, LBYTES, 8'hF8, 8'h1F);
        end
        check("reskip writes", wr_count, 0);
        check("reskip frame_done", fd_count, 0);
        vsync_pulse();
        clear_stats();
        send_frame(V, LBYTES, 8'hF8, 8'h1F);
        check_full_frame("after_rst");
        vsync_pulse();
        check("after_rst frame_done", fd_count, 1);
        check("after_rst frame_err", int'(frame_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
